// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  // Width of the WAIT down-counter; never narrower than one bit.
  function automatic int wait_cnt_w(input int wait_states);
    return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
  endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational grant selector: one-hot grant indexed by SEL_I/SEL_D,
// prio names the port that wins when both request.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (d_req && (!i_req || prio == SEL_D)) begin
      gnt[SEL_D] = 1'b1;
    end else if (i_req) begin
      gnt[SEL_I] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data port arbiter sharing one single-port synchronous RAM.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data-first.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [31:0]         i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [31:0]         d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int CW = wait_cnt_w(WAIT_STATES);

  // Handshake: a port raises req with stable fields and holds them until its
  // one-cycle ack; rdata is valid with ack and held until that port's next ack.
  arb_state_e    state;
  logic          sel;
  logic [CW-1:0] cnt;
  logic [1:0]    gnt;
  logic          prio;

  logic unused_addr;
  assign unused_addr = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                         d_addr[31:ADDR_W+2], d_addr[1:0]};

`ifdef MEM_ARB_RR_EN
  // Favour the port that was not served by the access just completed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio <= SEL_D;
    end else if (state == DONE) begin
      prio <= ~sel;
    end
  end
`else
  assign prio = SEL_D;
`endif

  mem_arb_sel u_sel (
    .i_req (i_req),
    .d_req (d_req),
    .prio  (prio),
    .gnt   (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sel       <= SEL_D;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            if (gnt[SEL_D]) begin
              sel       <= SEL_D;
              mem_addr  <= d_addr[ADDR_W+1:2];
              mem_wdata <= d_wdata;
              mem_we    <= d_we ? d_be : '0;
            end else begin
              sel      <= SEL_I;
              mem_addr <= i_addr[ADDR_W+1:2];
              mem_we   <= '0;
            end
          end
        end
        ISSUE: begin
          state  <= WAIT;
          mem_en <= 1'b0;
          mem_we <= '0;
          cnt    <= CW'(WAIT_STATES);
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= DONE;
            if (sel == SEL_D) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_ack   <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a WAIT_STATES=0 instance backed by a RAM
// model, and an ADDR_W=8 / WAIT_STATES=2 instance with bench-driven mem_rdata.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: ADDR_W=10, WAIT_STATES=0
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata;
  logic [3:0]  d_be, mem_we;
  logic        i_ack, d_ack, mem_en, busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  // Instance B: ADDR_W=8, WAIT_STATES=2
  logic        b_i_req, b_d_req, b_d_we;
  logic [31:0] b_i_addr, b_d_addr, b_d_wdata, b_i_rdata, b_d_rdata;
  logic [3:0]  b_d_be, b_mem_we;
  logic        b_i_ack, b_d_ack, b_mem_en, b_busy;
  logic [7:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .WAIT_STATES(0)) dut_a (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(2)) dut_b (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Single-port synchronous RAM with byte enables, one cycle read latency
  logic [31:0] ram [0:1023];
  logic [31:0] ram_w;
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      ram_w = ram[mem_addr];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram_w[8*b +: 8] = mem_wdata[8*b +: 8];
      end
      ram[mem_addr] <= ram_w;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    int bad;
    step();
    step();
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, i_ack, d_ack, busy} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got en=%b we=%h addr=%h wd=%h ia=%b da=%b busy=%b exp all 0",
               mem_en, mem_we, mem_addr, mem_wdata, i_ack, d_ack, busy);
    end
    checks++;
    if ({i_rdata, d_rdata} !== 64'd0) begin
      failures++;
      $display("FAIL reset_rdata got i=%h d=%h exp 0", i_rdata, d_rdata);
    end
    rst = 1'b1;
    step();
    // Fetch aborted by reset during WAIT
    i_req = 1'b1; i_addr = 32'h10;
    step();
    checks++;
    if (mem_en !== 1'b1) begin
      failures++;
      $display("FAIL abort_fetch_issue got mem_en=%b exp 1", mem_en);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_en, busy, mem_addr, i_ack} !== '0) begin
      failures++;
      $display("FAIL abort_wait got en=%b busy=%b addr=%h ack=%b exp all 0",
               mem_en, busy, mem_addr, i_ack);
    end
    i_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    // Store aborted by reset during ISSUE
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h80; d_wdata = 32'hFFFF_FFFF;
    step();
    checks++;
    if (mem_we !== 4'hF) begin
      failures++;
      $display("FAIL abort_store_issue got mem_we=%h exp f", mem_we);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we, busy} !== 6'd0) begin
      failures++;
      $display("FAIL abort_issue got en=%b we=%h busy=%b exp all 0", mem_en, mem_we, busy);
    end
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    step();
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (i_ack || d_ack || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL post_reset_idle got %0d active cycles exp 0", bad);
    end
    checks++;
    if (ram[32] !== 32'd0) begin
      failures++;
      $display("FAIL aborted_store got ram[32]=%h exp 00000000", ram[32]);
    end
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h10;
    step();
    checks++;
    if ({mem_en, mem_addr, mem_we, busy} !== {1'b1, 10'd4, 4'h0, 1'b1}) begin
      failures++;
      $display("FAIL fetch_issue got en=%b addr=%0d we=%h busy=%b exp en=1 addr=4 we=0 busy=1",
               mem_en, mem_addr, mem_we, busy);
    end
    step();
    checks++;
    if ({mem_en, i_ack} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_wait got en=%b ack=%b exp 0 0", mem_en, i_ack);
    end
    step();
    checks++;
    if ({i_ack, d_ack, i_rdata} !== {2'b10, 32'h2402_0005}) begin
      failures++;
      $display("FAIL fetch_ack got ia=%b da=%b rdata=%h exp ia=1 da=0 rdata=24020005",
               i_ack, d_ack, i_rdata);
    end
    i_req = 1'b0;
    step();
    checks++;
    if ({i_ack, busy} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_after got ack=%b busy=%b exp 0 0", i_ack, busy);
    end
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    step();
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {4'b0011, 10'd8, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL store_issue got we=%b addr=%0d wd=%h exp we=0011 addr=8 wd=deadbeef",
               mem_we, mem_addr, mem_wdata);
    end
    step();
    checks++;
    if (mem_we !== 4'b0000) begin
      failures++;
      $display("FAIL store_we_wait got we=%b exp 0000", mem_we);
    end
    step();
    checks++;
    if (d_ack !== 1'b1) begin
      failures++;
      $display("FAIL store_ack got d_ack=%b exp 1", d_ack);
    end
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    step();
    d_req = 1'b1;
    step();
    checks++;
    if ({mem_en, mem_we} !== {1'b1, 4'h0}) begin
      failures++;
      $display("FAIL load_issue got en=%b we=%b exp en=1 we=0000", mem_en, mem_we);
    end
    step();
    step();
    checks++;
    if ({d_ack, d_rdata} !== {1'b1, 32'h1234_BEEF}) begin
      failures++;
      $display("FAIL load_merged got ack=%b rdata=%h exp ack=1 rdata=1234beef", d_ack, d_rdata);
    end
    checks++;
    if (i_rdata !== 32'h2402_0005) begin
      failures++;
      $display("FAIL i_rdata_hold got %h exp 24020005", i_rdata);
    end
    d_req = 1'b0;
    step();
  endtask

  task automatic test_priority();
    int d_t, i_t;
    logic [31:0] d_rd, i_rd;
    pulse_reset();
    d_t = -1; i_t = -1; d_rd = '0; i_rd = '0;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (d_ack) begin d_t = c; d_rd = d_rdata; d_req = 1'b0; end
      if (i_ack) begin i_t = c; i_rd = i_rdata; i_req = 1'b0; end
    end
    checks++;
    if (d_t !== 3 || i_t !== 7) begin
      failures++;
      $display("FAIL tie_timing got d_ack@%0d i_ack@%0d exp d@3 i@7", d_t, i_t);
    end
    checks++;
    if (d_rd !== 32'hCAFE_F00D || i_rd !== 32'h0000_0011) begin
      failures++;
      $display("FAIL tie_data got d=%h i=%h exp d=cafef00d i=00000011", d_rd, i_rd);
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] order, exp_order;
    int n, both;
`ifdef MEM_ARB_RR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1111;
`endif
    pulse_reset();
    order = '0; n = 0; both = 0;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (d_ack && i_ack) both++;
      if (d_ack) begin order = {order[2:0], 1'b1}; n++; end
      if (i_ack) begin order = {order[2:0], 1'b0}; n++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    checks++;
    if (n !== 4 || both !== 0) begin
      failures++;
      $display("FAIL b2b_count got acks=%0d dual=%0d exp acks=4 dual=0", n, both);
    end
    checks++;
    if (order !== exp_order) begin
      failures++;
      $display("FAIL b2b_order got %b exp %b (1=data)", order, exp_order);
    end
    step();
    step();
  endtask

  task automatic test_wait_states();
    b_i_req = 1'b1; b_i_addr = 32'h10; b_mem_rdata = 32'hAAAA_0001;
    step();
    checks++;
    if ({b_mem_en, b_mem_addr} !== {1'b1, 8'd4}) begin
      failures++;
      $display("FAIL ws2_issue got en=%b addr=%0d exp en=1 addr=4", b_mem_en, b_mem_addr);
    end
    step();
    step();
    step();
    b_mem_rdata = 32'hBBBB_0002;
    checks++;
    if (b_i_ack !== 1'b0) begin
      failures++;
      $display("FAIL ws2_early got ack=%b exp 0 at T+4", b_i_ack);
    end
    step();
    b_mem_rdata = 32'hCCCC_0003;
    checks++;
    if ({b_i_ack, b_i_rdata} !== {1'b1, 32'hBBBB_0002}) begin
      failures++;
      $display("FAIL ws2_ack got ack=%b rdata=%h exp ack=1 rdata=bbbb0002", b_i_ack, b_i_rdata);
    end
    b_i_req = 1'b0;
    step();
    checks++;
    if ({b_i_rdata, b_busy} !== {32'hBBBB_0002, 1'b0}) begin
      failures++;
      $display("FAIL ws2_hold got rdata=%h busy=%b exp rdata=bbbb0002 busy=0", b_i_rdata, b_busy);
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] addrs [2];
    logic [7:0]  exp_word [2];
    bit got;
    addrs[0] = 32'h404; exp_word[0] = 8'd1;
    addrs[1] = 32'h13;  exp_word[1] = 8'd4;
    for (int k = 0; k < 2; k++) begin
      b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = addrs[k];
      step();
      checks++;
      if ({b_mem_en, b_mem_addr} !== {1'b1, exp_word[k]}) begin
        failures++;
        $display("FAIL wrap_addr[%0d] got en=%b addr=%0d exp en=1 addr=%0d",
                 k, b_mem_en, b_mem_addr, exp_word[k]);
      end
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        step();
        if (b_d_ack) got = 1'b1;
      end
      b_d_req = 1'b0;
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL wrap_ack[%0d] got no d_ack within 8 cycles exp ack", k);
      end
      step();
    end
  endtask

  initial begin
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    b_i_req = 0; b_i_addr = 0; b_d_req = 0; b_d_we = 0; b_d_be = 0; b_d_addr = 0;
    b_d_wdata = 0; b_mem_rdata = 0; mem_rdata = 0;
    for (int k = 0; k < 1024; k++) ram[k] = 32'd0;
    ram[0]  = 32'h0000_0011;
    ram[4]  = 32'h2402_0005;
    ram[8]  = 32'h1234_5678;
    ram[16] = 32'hCAFE_F00D;
    rst = 1'b0;
    test_reset();
    test_fetch();
    test_store_load();
    test_priority();
    test_back_to_back();
    test_wait_states();
    test_addr_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
